// File: rtl/psum_writer_pkg.sv
// Shared definitions for the partial-sum writer: FSM encoding, SRAM strobe levels
// and default geometry. Imported by the writer and by the corelet controller.
package psum_writer_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned DATA_W  = COL * PSUM_BW;

    // SRAM strobes are active-low
    localparam logic CEN_IDLE   = 1'b1;
    localparam logic CEN_ACTIVE = 1'b0;
    localparam logic WEN_READ   = 1'b1;
    localparam logic WEN_WRITE  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // States in which a transfer is in flight
    function automatic logic is_busy(input state_t s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/psum_writer_relu_lane.sv
// One-lane ReLU clamp for the partial-sum writer: negative signed lanes become
// zero, non-negative lanes pass through. Only built when PSUM_WRITER_RELU_EN is set.
`ifdef PSUM_WRITER_RELU_EN
module relu_lane #(
    parameter int unsigned psum_bw = 16
) (
    input  logic [psum_bw-1:0] lane,
    output logic [psum_bw-1:0] clamped_c
);

    // Sign bit selects between the lane value and zero
    always_comb begin
        clamped_c = lane;
        if (lane[psum_bw-1]) begin
            clamped_c = '0;
        end
    end

endmodule
`endif

// File: rtl/psum_writer.sv
// Partial-sum writer: pops vectors from the OFIFO and writes each one into
// consecutive output-SRAM words starting at a programmed base address.
// Optional feature macro: PSUM_WRITER_RELU_EN (clamp negative lanes to zero on write).
module psum_writer
    import psum_writer_pkg::*;
#(
    parameter int unsigned col     = COL,
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned addr_w  = ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_w-1:0]        base_addr,
    input  logic [addr_w:0]          num_vec,
    input  logic [col*psum_bw-1:0]   ofifo_out,
    input  logic                     ofifo_valid,
    output logic                     ofifo_rd,
    output logic                     CEN,
    output logic                     WEN,
    output logic [addr_w-1:0]        A,
    output logic [col*psum_bw-1:0]   D,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned DW = col * psum_bw;
    localparam int unsigned CW = addr_w + 1;

    state_t            state;
    state_t            state_nxt;
    logic [addr_w-1:0] addr_ptr;
    logic [CW-1:0]     remaining;
    logic [DW-1:0]     d_next_c;

    // Lane transform applied in front of the D register
`ifdef PSUM_WRITER_RELU_EN
    for (genvar i = 0; i < int'(col); i++) begin : g_relu
        relu_lane #(
            .psum_bw   (psum_bw)
        ) u_relu (
            .lane      (ofifo_out[i*psum_bw +: psum_bw]),
            .clamped_c (d_next_c[i*psum_bw +: psum_bw])
        );
    end
`else
    assign d_next_c = ofifo_out;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the combinational OFIFO pop
    always_comb begin
        state_nxt = state;
        ofifo_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_vec != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                ofifo_rd = ofifo_valid;
                if (ofifo_valid && (remaining == CW'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status flags, registered from the next state so they line up with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= is_busy(state_nxt);
            done <= (state_nxt == DONE);
        end
    end

    // Address/count tracking: loaded on an accepted start, stepped on every pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_ptr  <= '0;
            remaining <= '0;
        end else if ((state == IDLE) && start) begin
            addr_ptr  <= base_addr;
            remaining <= num_vec;
        end else if (ofifo_rd) begin
            addr_ptr  <= addr_ptr + addr_w'(1);
            remaining <= remaining - CW'(1);
        end
    end

    // SRAM write stage: one registered write per pop, strobes idle otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CEN <= CEN_IDLE;
            WEN <= WEN_READ;
            A   <= '0;
            D   <= '0;
        end else if (ofifo_rd) begin
            CEN <= CEN_ACTIVE;
            WEN <= WEN_WRITE;
            A   <= addr_ptr;
            D   <= d_next_c;
        end else begin
            CEN <= CEN_IDLE;
            WEN <= WEN_READ;
        end
    end

endmodule

// File: tb/tb_psum_writer.sv
// Directed self-checking bench for psum_writer. Honors PSUM_WRITER_RELU_EN for
// the expected write data.
module tb_psum_writer;
    import psum_writer_pkg::*;

    localparam int MAX_CYC = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [10:0]       base_addr;
    logic [11:0]       num_vec;
    logic [127:0]      ofifo_out;
    logic              ofifo_valid;
    logic              ofifo_rd;
    logic              cen;
    logic              wen;
    logic [10:0]       a;
    logic [127:0]      d;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] fifo[$];
    logic         gate;
    logic         gate_pat[$];
    int           pops;
    logic [10:0]  wr_a[$];
    logic [127:0] wr_d[$];
    int           wr_c[$];
    int           done_cyc;
    int           done_cnt;
    int           busy_in_done;
    int           cyc;

    psum_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .num_vec     (num_vec),
        .ofifo_out   (ofifo_out),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd),
        .CEN         (cen),
        .WEN         (wen),
        .A           (a),
        .D           (d),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mkvec(input int s);
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'((s << 4) + i) & 16'h7FFF;
        return v;
    endfunction

    function automatic logic [127:0] exp_vec(input logic [127:0] v);
        logic [127:0] r;
        r = v;
`ifdef PSUM_WRITER_RELU_EN
        for (int i = 0; i < 8; i++) if (v[i*16 + 15]) r[i*16 +: 16] = 16'h0000;
`endif
        return r;
    endfunction

    task automatic refresh();
        ofifo_valid = gate && (fifo.size() > 0);
        ofifo_out   = (fifo.size() > 0) ? fifo[0] : 128'h0;
    endtask

    // Advance one clock; pops the bench OFIFO when the DUT popped this cycle
    task automatic step();
        logic rd;
        #1;
        rd = ofifo_rd;
        @(posedge clk);
        #1;
        if (rd) begin
            if (fifo.size() > 0) void'(fifo.pop_front());
            pops++;
        end
        refresh();
    endtask

    // Start a transfer and record every write and done pulse, cycle 1 = first after start is sampled
    task automatic run_xfer(input logic [10:0] b, input logic [11:0] n, input int poke);
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        done_cyc = -1; done_cnt = 0; busy_in_done = 0; pops = 0;
        base_addr = b; num_vec = n; start = 1'b1;
        gate = 1'b1; refresh();
        step();
        start = 1'b0; base_addr = 11'h555; num_vec = 12'd0;
        cyc = 1;
        while (1) begin
            if (cen == 1'b0) begin wr_a.push_back(a); wr_d.push_back(d); wr_c.push_back(cyc); end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (busy) busy_in_done = 1;
            end
            if (cyc >= MAX_CYC || (done_cyc >= 0 && cyc >= done_cyc + 2)) break;
            gate  = (gate_pat.size() > 0) ? gate_pat.pop_front() : 1'b1;
            start = (cyc == poke);
            refresh();
            step();
            start = 1'b0;
            cyc++;
        end
        gate = 1'b1; refresh();
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: done never seen within %0d cycles", MAX_CYC);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start       = 1'($urandom_range(0, 1));
            ofifo_valid = 1'($urandom_range(0, 1));
            base_addr   = 11'($urandom);
            num_vec     = 12'($urandom);
            ofifo_out   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            @(posedge clk); #1;
            n_checks++; if (cen !== 1'b1)      begin n_fail++; $display("FAIL reset_cen got %b want 1", cen); end
            n_checks++; if (wen !== 1'b1)      begin n_fail++; $display("FAIL reset_wen got %b want 1", wen); end
            n_checks++; if (ofifo_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd got %b want 0", ofifo_rd); end
            n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
            n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        end
        n_checks++; if (a !== 11'h0 || d !== 128'h0) begin n_fail++; $display("FAIL reset_ad got A=%h D=%h want 0", a, d); end
        start = 1'b0; base_addr = '0; num_vec = '0; gate = 1'b1;
        fifo.delete(); refresh();
        reset = 1'b1;
        step(); step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) fifo.push_back(mkvec(i + 1));
        run_xfer(11'h010, 12'd4, -1);
        n_checks++; if (wr_a.size() !== 4) begin n_fail++; $display("FAIL basic_count got %0d want 4", wr_a.size()); end
        for (int i = 0; i < 4 && i < wr_a.size(); i++) begin
            n_checks++; if (wr_a[i] !== 11'(16 + i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h want %h", i, wr_a[i], 11'(16 + i)); end
            n_checks++; if (wr_d[i] !== exp_vec(mkvec(i + 1))) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, wr_d[i], exp_vec(mkvec(i + 1))); end
            n_checks++; if (wr_c[i] !== 2 + i) begin n_fail++; $display("FAIL basic_wcyc[%0d] got %0d want %0d", i, wr_c[i], 2 + i); end
        end
        n_checks++; if (done_cyc !== 6)   begin n_fail++; $display("FAIL basic_done_cyc got %0d want 6", done_cyc); end
        n_checks++; if (done_cnt !== 1)   begin n_fail++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
        n_checks++; if (pops !== 4)       begin n_fail++; $display("FAIL basic_pops got %0d want 4", pops); end
        n_checks++; if (busy_in_done !== 0) begin n_fail++; $display("FAIL basic_busy_in_done got %0d want 0", busy_in_done); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) fifo.push_back(mkvec(i + 9));
        run_xfer(11'h7FE, 12'd3, -1);
        n_checks++; if (wr_a.size() !== 3) begin n_fail++; $display("FAIL wrap_count got %0d want 3", wr_a.size()); end
        if (wr_a.size() == 3) begin
            n_checks++; if (wr_a[0] !== 11'h7FE) begin n_fail++; $display("FAIL wrap_a0 got %h want 7fe", wr_a[0]); end
            n_checks++; if (wr_a[1] !== 11'h7FF) begin n_fail++; $display("FAIL wrap_a1 got %h want 7ff", wr_a[1]); end
            n_checks++; if (wr_a[2] !== 11'h000) begin n_fail++; $display("FAIL wrap_a2 got %h want 000", wr_a[2]); end
            n_checks++; if (wr_d[2] !== exp_vec(mkvec(11))) begin n_fail++; $display("FAIL wrap_d2 got %h want %h", wr_d[2], exp_vec(mkvec(11))); end
        end
    endtask

    task automatic test_bubbles();
        fifo.push_back(mkvec(20)); fifo.push_back(mkvec(21));
        gate_pat.delete();
        gate_pat.push_back(1'b1); gate_pat.push_back(1'b0); gate_pat.push_back(1'b0); gate_pat.push_back(1'b1);
        run_xfer(11'h100, 12'd2, -1);
        n_checks++; if (pops !== 2) begin n_fail++; $display("FAIL bubble_pops got %0d want 2", pops); end
        n_checks++; if (wr_c.size() !== 2) begin n_fail++; $display("FAIL bubble_count got %0d want 2", wr_c.size()); end
        if (wr_c.size() == 2) begin
            n_checks++; if (wr_c[0] !== 2 || wr_c[1] !== 5) begin n_fail++; $display("FAIL bubble_wcyc got %0d,%0d want 2,5", wr_c[0], wr_c[1]); end
            n_checks++; if (wr_a[1] !== 11'h101 || wr_d[1] !== exp_vec(mkvec(21))) begin n_fail++; $display("FAIL bubble_w1 got A=%h D=%h want A=101 D=%h", wr_a[1], wr_d[1], exp_vec(mkvec(21))); end
        end
        n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL bubble_done_cyc got %0d want 6", done_cyc); end
    endtask

    task automatic test_zero_and_restart();
        fifo.push_back(mkvec(30));
        run_xfer(11'h200, 12'd0, -1);
        n_checks++; if (pops !== 0)        begin n_fail++; $display("FAIL zero_pops got %0d want 0", pops); end
        n_checks++; if (wr_a.size() !== 0) begin n_fail++; $display("FAIL zero_writes got %0d want 0", wr_a.size()); end
        n_checks++; if (done_cyc !== 1)    begin n_fail++; $display("FAIL zero_done_cyc got %0d want 1", done_cyc); end
        n_checks++; if (done_cnt !== 1)    begin n_fail++; $display("FAIL zero_done_cnt got %0d want 1", done_cnt); end
        fifo.delete();
        for (int i = 0; i < 3; i++) fifo.push_back(mkvec(i + 40));
        run_xfer(11'h300, 12'd3, 2);
        n_checks++; if (wr_a.size() !== 3) begin n_fail++; $display("FAIL restart_count got %0d want 3", wr_a.size()); end
        if (wr_a.size() == 3) begin
            n_checks++; if (wr_a[2] !== 11'h302) begin n_fail++; $display("FAIL restart_a2 got %h want 302", wr_a[2]); end
        end
        n_checks++; if (done_cyc !== 5 || done_cnt !== 1) begin n_fail++; $display("FAIL restart_done got cyc=%0d cnt=%0d want 5,1", done_cyc, done_cnt); end
    endtask

    task automatic test_relu();
        logic [127:0] in_v;
        logic [127:0] want;
        in_v = {4{16'h7FFF, 16'h8001}};
`ifdef PSUM_WRITER_RELU_EN
        want = {4{16'h7FFF, 16'h0000}};
`else
        want = {4{16'h7FFF, 16'h8001}};
`endif
        fifo.push_back(in_v);
        run_xfer(11'h0A0, 12'd1, -1);
        n_checks++; if (wr_d.size() !== 1) begin n_fail++; $display("FAIL relu_count got %0d want 1", wr_d.size()); end
        if (wr_d.size() == 1) begin
            n_checks++; if (wr_d[0] !== want) begin n_fail++; $display("FAIL relu_data got %h want %h", wr_d[0], want); end
        end
    endtask

    task automatic test_full_range();
        logic [2047:0] seen;
        int dup;
        seen = '0; dup = 0;
        for (int i = 0; i < 2048; i++) fifo.push_back(mkvec(i));
        run_xfer(11'h123, 12'd2048, -1);
        for (int i = 0; i < wr_a.size(); i++) begin
            if (seen[wr_a[i]]) dup++;
            seen[wr_a[i]] = 1'b1;
        end
        n_checks++; if (wr_a.size() !== 2048) begin n_fail++; $display("FAIL full_count got %0d want 2048", wr_a.size()); end
        n_checks++; if (dup !== 0 || seen !== {2048{1'b1}}) begin n_fail++; $display("FAIL full_cover got dup=%0d all=%b want 0,1", dup, &seen); end
        n_checks++; if (done_cyc !== 2050) begin n_fail++; $display("FAIL full_done_cyc got %0d want 2050", done_cyc); end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 4; i++) fifo.push_back(mkvec(i + 60));
        base_addr = 11'h020; num_vec = 12'd4; start = 1'b1;
        gate = 1'b1; refresh();
        step();
        start = 1'b0;
        step(); step();
        n_checks++; if (cen !== 1'b0) begin n_fail++; $display("FAIL midrst_pre_cen got %b want 0", cen); end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (cen !== 1'b1 || wen !== 1'b1) begin n_fail++; $display("FAIL midrst_cen got CEN=%b WEN=%b want 1,1", cen, wen); end
        n_checks++; if (busy !== 1'b0 || ofifo_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got busy=%b rd=%b want 0,0", busy, ofifo_rd); end
        step(); step();
        reset = 1'b1;
        pops = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (cen !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_post[%0d] got CEN=%b busy=%b want 1,0", k, cen, busy); end
        end
        n_checks++; if (pops !== 0) begin n_fail++; $display("FAIL midrst_pops got %0d want 0", pops); end
        fifo.delete(); refresh();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; base_addr = '0; num_vec = '0;
        gate = 1'b1; ofifo_out = '0; ofifo_valid = 1'b0; pops = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_bubbles();
        test_zero_and_restart();
        test_relu();
        test_full_range();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
